// File: rtl/des_pkg.sv
// des_pkg: DES round-engine constants, FSM states and S-box lookup tables
package des_pkg;
    localparam int DES_ROUNDS = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int E_TABLE [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                                    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                                    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_TABLE [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // Each table holds 64 nibbles, entry row*16+col first from the MSB end
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    function automatic logic [3:0] sbox_lookup(input logic [255:0] t, input logic [5:0] b);
        return 4'(t >> (4 * (63 - int'({b[5], b[0], b[4:1]}))));
    endfunction
endpackage

// File: rtl/des_round_engine_if.sv
// des_round_engine_if: block handshake and key-schedule port of the DES round engine
interface des_round_engine_if;
    logic        in_valid, in_ready, decrypt, out_valid, out_ready;
    logic [63:0] in_block, out_block;
    logic [3:0]  key_idx;
    logic [47:0] subkey;
    modport master (output in_valid, in_block, decrypt, subkey, out_ready,
                    input  in_ready, key_idx, out_valid, out_block);
    modport slave  (input  in_valid, in_block, decrypt, subkey, out_ready,
                    output in_ready, key_idx, out_valid, out_block);
endinterface

// File: rtl/des_f_function.sv
// des_f_function: combinational DES f-function (E, key mix, S-boxes, P) and its eight S-boxes
module s_box_1 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S1, b); endmodule
module s_box_2 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S2, b); endmodule
module s_box_3 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S3, b); endmodule
module s_box_4 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S4, b); endmodule
module s_box_5 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S5, b); endmodule
module s_box_6 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S6, b); endmodule
module s_box_7 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S7, b); endmodule
module s_box_8 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s); assign s = sbox_lookup(S8, b); endmodule

module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);
    logic [47:0] e, x;
    logic [31:0] s;
    // DES bit n (1 = MSB) of an N-bit word is index N-n
    for (genvar i = 0; i < 48; i++) begin : g_e
        assign e[47 - i] = r[32 - E_TABLE[i]];
    end
    assign x = e ^ k;
    s_box_1 u_s1 (.b(x[47:42]), .s(s[31:28]));
    s_box_2 u_s2 (.b(x[41:36]), .s(s[27:24]));
    s_box_3 u_s3 (.b(x[35:30]), .s(s[23:20]));
    s_box_4 u_s4 (.b(x[29:24]), .s(s[19:16]));
    s_box_5 u_s5 (.b(x[23:18]), .s(s[15:12]));
    s_box_6 u_s6 (.b(x[17:12]), .s(s[11:8]));
    s_box_7 u_s7 (.b(x[11:6]),  .s(s[7:4]));
    s_box_8 u_s8 (.b(x[5:0]),   .s(s[3:0]));
    for (genvar i = 0; i < 32; i++) begin : g_p
        assign f[31 - i] = s[32 - P_TABLE[i]];
    end
endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel core, one round per clock, between the IP and FP stages
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
) (
    input logic clk,
    input logic rst_n,
    des_round_engine_if.slave bus
);
    state_t      state;
    logic [31:0] l, r, f;
    logic [3:0]  cnt, key_idx;
    logic [63:0] out_block;
    logic        dec, in_ready, out_valid, last;
    assign last = cnt == 4'(ROUNDS - 1);
    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_block = out_block;
    assign bus.key_idx = key_idx;
    des_f_function u_f (.r(r), .k(bus.subkey), .f(f));
    // key_idx is registered, so it is loaded one step ahead with the next round's index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_block <= '0;
            key_idx <= '0;
            l <= '0;
            r <= '0;
            cnt <= '0;
            dec <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    l <= bus.in_block[63:32];
                    r <= bus.in_block[31:0];
                    dec <= bus.decrypt;
                    cnt <= '0;
                    key_idx <= bus.decrypt ? 4'(ROUNDS - 1) : 4'd0;
                    in_ready <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    l <= r;
                    r <= l ^ f;
                    cnt <= cnt + 4'd1;
                    key_idx <= last ? 4'd0 : dec ? 4'(ROUNDS - 2) - cnt : cnt + 4'd1;
                    if (last) begin
                        out_block <= {l ^ f, r};
                        out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: known-answer, table-driven and randomized checks of the DES round engine
module tb_des_round_engine;
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [63:0] KAT_CT = 64'h0A4CD995_43423234;
    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35,
                                27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38,
                                30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7,
                                27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56,
                                34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    typedef struct {
        logic [63:0] blk;
        bit          dec;
        logic [63:0] exp;
        int          hold;
        bit          probe;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_q [$];
    logic [63:0] out_q [$];
    logic [47:0] ks [16];
    logic [31:0] fr, ff;
    logic [47:0] fk;

    always #5 clk = ~clk;

    des_round_engine_if bus ();
    des_round_engine #(.ROUNDS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    des_f_function u_fchk (.r(fr), .k(fk), .f(ff));

    always_comb bus.subkey = ks[bus.key_idx];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_block);
    end

    function automatic void make_ks(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFTS[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47 - i] = cd[56 - PC2[i]];
        end
    endfunction

    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, o;
        logic [255:0] t;
        int v, row, col;
        for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_T[i]];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            v = int'(x[47 - 6 * j -: 6]);
            row = (v >> 5) * 2 + (v & 1);
            col = (v >> 1) & 15;
            t = SB[j];
            s[31 - 4 * j -: 4] = t[255 - 4 * (row * 16 + col) -: 4];
        end
        for (int i = 0; i < 32; i++) o[31 - i] = s[32 - P_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] b, input bit dec);
        logic [31:0] l, r, t;
        l = b[63:32];
        r = b[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_ref(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        return {r, l};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [63:0] blk, input bit dec);
        int n = 0;
        bus.in_block = blk;
        bus.decrypt = dec;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_block = ~blk;
        bus.decrypt = ~dec;
    endtask

    task automatic run_block(input logic [63:0] blk, input bit dec, input logic [63:0] exp, input bit probe);
        accept(blk, dec);
        for (int i = 0; i < 16; i++) begin
            chk("key_idx", 64'(bus.key_idx), 64'(dec ? 15 - i : i));
            chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            chk("early_out_valid", 64'(bus.out_valid), 64'd0);
            if (probe && i == 0) chk("k1_subkey", 64'(bus.subkey), 64'h1B02EFFC7072);
            if (probe && i == 1) chk("round1_lr", {dut.l, dut.r}, 64'hF0AAF0AA_EF4A6544);
            @(negedge clk);
        end
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_block", bus.out_block, exp);
    endtask

    task automatic drain(input int hold, input logic [63:0] exp);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.in_block = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_block", bus.out_block, exp);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        vec_t vt [6];
        logic [63:0] key, blk, exp, b2;
        bit dec;
        int a0, o0, n;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.decrypt = 1'b0;
        bus.out_ready = 1'b0;
        fr = '0;
        fk = '0;
        make_ks(KEY);
        #2 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_block", bus.out_block, 64'd0);
        chk("rst_key_idx", 64'(bus.key_idx), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("ref_f_kat", 64'(f_ref(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h234AA9BB);
        fr = 32'hF0AAF0AA;
        fk = 48'h1B02EFFC7072;
        #1 chk("f_kat", 64'(ff), 64'h234AA9BB);
        for (int i = 0; i < 8; i++) begin
            fr = $urandom;
            fk = {16'($urandom), $urandom};
            #1 chk("f_rand", 64'(ff), 64'(f_ref(fr, fk)));
        end

        vt[0] = '{KAT_PT, 1'b0, KAT_CT, 0, 1'b1};
        vt[1] = '{KAT_CT, 1'b1, KAT_PT, 0, 1'b0};
        vt[2] = '{KAT_PT, 1'b0, KAT_CT, 10, 1'b0};
        vt[3] = '{64'd0, 1'b0, des_ref(64'd0, 1'b0), 1, 1'b0};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, des_ref(64'hFFFF_FFFF_FFFF_FFFF, 1'b1), 0, 1'b0};
        blk = {$urandom, $urandom};
        vt[5] = '{blk, 1'b1, des_ref(blk, 1'b1), 2, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run_block(vt[i].blk, vt[i].dec, vt[i].exp, vt[i].probe);
            drain(vt[i].hold, vt[i].exp);
        end

        accept(KAT_PT, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_key_idx", 64'(bus.key_idx), 64'd0);
        chk("midrst_out_block", bus.out_block, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(KAT_PT, 1'b0, KAT_CT, 1'b0);
        drain(0, KAT_CT);

        b2 = {$urandom, $urandom};
        a0 = acc_q.size();
        o0 = out_q.size();
        n = 0;
        bus.in_block = KAT_PT;
        bus.decrypt = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        while (out_q.size() < o0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (acc_q.size() == a0 + 1) bus.in_block = b2;
            if (acc_q.size() >= a0 + 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_outputs", 64'(out_q.size() - o0), 64'd2);
        chk("b2b_gap", 64'(acc_q.size() >= a0 + 2 ? acc_q[a0 + 1] - acc_q[a0] : 0), 64'd18);
        chk("b2b_first", out_q.size() >= o0 + 1 ? out_q[o0] : 64'd0, KAT_CT);
        chk("b2b_second", out_q.size() >= o0 + 2 ? out_q[o0 + 1] : 64'd0, des_ref(b2, 1'b0));
        @(negedge clk);

        for (int t = 0; t < 12; t++) begin
            key = {$urandom, $urandom};
            make_ks(key);
            blk = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            exp = des_ref(blk, dec);
            run_block(blk, dec, exp, 1'b0);
            drain(int'($urandom_range(0, 3)), exp);
            run_block(exp, ~dec, blk, 1'b0);
            drain(0, blk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
